id_ex_control_stage: RTL and testbench

Main control decoder and ID/EX pipeline register for the five-stage pipeline. It decodes the ID-stage opcode into datapath control bits, including the 2-bit `ALUOp`, which the EX-stage ALU control decoder combines with the forwarded `funct` field. It registers those bits with the register specifiers into the ID/EX stage. It also detects load-use hazards locally and inserts bubbles on stall or branch flush.

---
 rtl/id_ex_control_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_control_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_control_stage.sv
// Main control decoder, load-use hazard detection and ID/EX pipeline register.
// Optional feature macro: JUMP_EN (decode j in ID and drive id_jump).
module id_ex_control_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             flush,
  output logic             stall,
`ifdef JUMP_EN
  output logic             id_jump,
`endif
  output logic             ex_RegDst,
  output logic             ex_ALUSrc,
  output logic             ex_MemtoReg,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_Branch,
  output logic [1:0]       ex_ALUOp,
  output logic [5:0]       ex_funct,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       illegal;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  uses_rt;
  logic  jump_op;
  logic  hazard;
  logic  load_bubble;
  idex_t ex;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    uses_rt     = 1'b0;
    jump_op     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        uses_rt            = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
        uses_rt         = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
`ifdef JUMP_EN
      OP_J:    jump_op = 1'b1;
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  // A load in EX whose destination feeds the ID instruction must wait one cycle;
  // a flush squashes that instruction anyway, so it never stalls.
  assign hazard = ex.ctrl.mem_read && (ex.rt != 5'd0) &&
                  ((ex.rt == id_rs) || (uses_rt && (ex.rt == id_rt)));
  assign stall  = hazard && !flush;

`ifdef JUMP_EN
  assign id_jump = jump_op && !stall && !flush;
`endif

  // Jumps resolve in ID, so they also leave a bubble behind in EX.
  assign load_bubble = flush || stall || jump_op;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= BUBBLE;
    end else if (load_bubble) begin
      ex <= BUBBLE;
    end else begin
      ex.ctrl    <= dec_ctrl;
      ex.funct   <= funct;
      ex.rs      <= id_rs;
      ex.rt      <= id_rt;
      ex.rd      <= id_rd;
      ex.illegal <= dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_RegDst   = ex.ctrl.reg_dst;
  assign ex_ALUSrc   = ex.ctrl.alu_src;
  assign ex_MemtoReg = ex.ctrl.mem_to_reg;
  assign ex_RegWrite = ex.ctrl.reg_write;
  assign ex_MemRead  = ex.ctrl.mem_read;
  assign ex_MemWrite = ex.ctrl.mem_write;
  assign ex_Branch   = ex.ctrl.branch;
  assign ex_ALUOp    = ex.ctrl.alu_op;
  assign ex_funct    = ex.funct;
  assign ex_rs       = ex.rs;
  assign ex_rt       = ex.rt;
  assign ex_rd       = ex.rd;
  assign ex_illegal  = ex.illegal;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Self-checking bench for id_ex_control_stage: vector table plus hand sequences
// for saturation, asynchronous reset and the optional jump decode.
module tb_id_ex_control_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic       stall;
`ifdef JUMP_EN
  logic       id_jump;
`endif
  logic       ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
  logic       ex_MemRead, ex_MemWrite, ex_Branch;
  logic [1:0] ex_ALUOp;
  logic [5:0] ex_funct;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_illegal;
  logic [7:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_control_stage #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .flush      (flush),
    .stall      (stall),
`ifdef JUMP_EN
    .id_jump    (id_jump),
`endif
    .ex_RegDst  (ex_RegDst),
    .ex_ALUSrc  (ex_ALUSrc),
    .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite),
    .ex_MemRead (ex_MemRead),
    .ex_MemWrite(ex_MemWrite),
    .ex_Branch  (ex_Branch),
    .ex_ALUOp   (ex_ALUOp),
    .ex_funct   (ex_funct),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_illegal (ex_illegal),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Control order: RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]
  localparam logic [8:0] C_R    = 9'b100100010;
  localparam logic [8:0] C_LW   = 9'b011110000;
  localparam logic [8:0] C_SW   = 9'b010001000;
  localparam logic [8:0] C_BEQ  = 9'b000000101;
  localparam logic [8:0] C_ADDI = 9'b010100000;
  localparam logic [8:0] C_NONE = 9'b000000000;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       exp_stall;
    logic       exp_bubble;
    logic [8:0] exp_ctrl;
    logic       exp_ill;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic fl,
                              input logic exp_stall, input logic exp_bubble,
                              input logic [8:0] exp_ctrl, input logic exp_ill,
                              input logic [7:0] exp_cnt);
    vec_t v;
    v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.rd = rd; v.fl = fl;
    v.exp_stall = exp_stall; v.exp_bubble = exp_bubble;
    v.exp_ctrl = exp_ctrl; v.exp_ill = exp_ill; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_now();
    return {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
            ex_MemWrite, ex_Branch, ex_ALUOp};
  endfunction

  task automatic check_all_clear(input string tag);
    check({tag, " ctrl"}, 32'(ctrl_now()), 32'(C_NONE));
    check({tag, " regs"}, 32'({ex_funct, ex_rs, ex_rt, ex_rd, ex_illegal}), 32'd0);
    check({tag, " stall"}, 32'(stall), 32'd0);
    check({tag, " cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; flush = 1'b0;

    //       op         funct      rs rt rd fl  stall bub ctrl    ill cnt
    tbl.push_back(mk(6'b000000, 6'b100000, 1, 2, 3, 0, 0, 0, C_R,    0, 0)); // add
    tbl.push_back(mk(6'b100011, 6'b000000, 1, 5, 0, 0, 0, 0, C_LW,   0, 0)); // lw rt=5
    tbl.push_back(mk(6'b000000, 6'b100010, 5, 6, 7, 0, 1, 1, C_NONE, 0, 1)); // load-use on rs
    tbl.push_back(mk(6'b000000, 6'b100010, 5, 6, 7, 0, 0, 0, C_R,    0, 1)); // held R proceeds
    tbl.push_back(mk(6'b100011, 6'b000000, 2, 5, 0, 0, 0, 0, C_LW,   0, 1)); // lw rt=5
    tbl.push_back(mk(6'b001000, 6'b000000, 7, 5, 0, 0, 0, 0, C_ADDI, 0, 1)); // addi rt not source
    tbl.push_back(mk(6'b100011, 6'b000000, 0, 0, 0, 0, 0, 0, C_LW,   0, 1)); // lw rt=0
    tbl.push_back(mk(6'b000000, 6'b100101, 0, 0, 4, 0, 0, 0, C_R,    0, 1)); // rs=0 no stall
    tbl.push_back(mk(6'b100011, 6'b000000, 3, 9, 0, 0, 0, 0, C_LW,   0, 1)); // lw rt=9
    tbl.push_back(mk(6'b101011, 6'b000000, 1, 9, 0, 1, 0, 1, C_NONE, 0, 1)); // hazard + flush
    tbl.push_back(mk(6'b000100, 6'b000000, 4, 8, 0, 0, 0, 0, C_BEQ,  0, 1)); // beq
    tbl.push_back(mk(6'b101011, 6'b000000, 2, 3, 0, 0, 0, 0, C_SW,   0, 1)); // sw
    tbl.push_back(mk(6'b111111, 6'b000001, 1, 2, 3, 0, 0, 0, C_NONE, 1, 1)); // unknown opcode
`ifdef JUMP_EN
    tbl.push_back(mk(6'b000010, 6'b000000, 1, 2, 3, 0, 0, 1, C_NONE, 0, 1)); // j -> bubble
`else
    tbl.push_back(mk(6'b000010, 6'b000000, 1, 2, 3, 0, 0, 0, C_NONE, 1, 1)); // j illegal
`endif
    tbl.push_back(mk(6'b100011, 6'b000000, 0, 5, 0, 0, 0, 0, C_LW,   0, 1)); // lw rt=5
    tbl.push_back(mk(6'b101011, 6'b000000, 0, 5, 0, 0, 1, 1, C_NONE, 0, 2)); // load-use on rt
    tbl.push_back(mk(6'b101011, 6'b000000, 0, 5, 0, 0, 0, 0, C_SW,   0, 2)); // held sw proceeds
    tbl.push_back(mk(6'b000000, 6'b100000, 1, 2, 3, 1, 0, 1, C_NONE, 0, 2)); // plain flush

    #1;
    check_all_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      opcode = tbl[i].op; funct = tbl[i].fn;
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_rd = tbl[i].rd; flush = tbl[i].fl;
      #1;
      check($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].exp_stall));
      @(posedge clk);
      #1;
      check($sformatf("row%0d ctrl", i), 32'(ctrl_now()), 32'(tbl[i].exp_ctrl));
      check($sformatf("row%0d illegal", i), 32'(ex_illegal), 32'(tbl[i].exp_ill));
      check($sformatf("row%0d funct", i), 32'(ex_funct),
            tbl[i].exp_bubble ? 32'd0 : 32'(tbl[i].fn));
      check($sformatf("row%0d rs", i), 32'(ex_rs), tbl[i].exp_bubble ? 32'd0 : 32'(tbl[i].rs));
      check($sformatf("row%0d rt", i), 32'(ex_rt), tbl[i].exp_bubble ? 32'd0 : 32'(tbl[i].rt));
      check($sformatf("row%0d rd", i), 32'(ex_rd), tbl[i].exp_bubble ? 32'd0 : 32'(tbl[i].rd));
      check($sformatf("row%0d cnt", i), 32'(stall_cnt), 32'(tbl[i].exp_cnt));
    end

    // lw r5,(r5) held in ID: stalls on every other edge, 300 stalls in 601 edges.
    @(negedge clk);
    opcode = 6'b100011; funct = 6'd0; id_rs = 5'd5; id_rt = 5'd5; id_rd = 5'd0; flush = 1'b0;
    for (int c = 0; c < 601; c++) @(posedge clk);
    #1;
    check("sat cnt", 32'(stall_cnt), 32'd255);
    check("sat stall pending", 32'(stall), 32'd1);
    check("sat ex lw", 32'(ctrl_now()), 32'(C_LW));

    // Asynchronous reset mid-cycle with a bubble pending.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_clear("midreset");
    opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset cnt", 32'(stall_cnt), 32'd0);

`ifdef JUMP_EN
    @(negedge clk);
    opcode = 6'b000010; flush = 1'b0;
    #1;
    check("jump id_jump", 32'(id_jump), 32'd1);
    flush = 1'b1;
    #1;
    check("jump flushed", 32'(id_jump), 32'd0);
    flush = 1'b0;
    @(posedge clk);
    #1;
    check("jump illegal", 32'(ex_illegal), 32'd0);
    check("jump bubble", 32'(ctrl_now()), 32'(C_NONE));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
